// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-credit vending controller with dispenser and change-payout handshakes.
// Optional: define VEND_TIMEOUT_EN to build the dispense-ack watchdog (fault pulse, price refund, CHANGE).
module vend_sequencer #(
    parameter int unsigned MAX_BAL     = 100,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    output logic       disp_req,
    input  logic       disp_ack,
    output logic [1:0] disp_item,
    output logic       chg_req,
    input  logic       chg_ack,
    output logic [7:0] balance,
    output logic       busy,
    output logic       coin_rej,
    output logic       sel_rej,
    output logic       fault
);

    // state  | meaning
    // IDLE   | accepting coins, selection and cancel
    // VEND   | disp_req high, waiting for disp_ack
    // CHANGE | chg_req high, one 5-unit coin paid per chg_ack
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [8:0] MAX_BAL_W = 9'(MAX_BAL);
    localparam logic [7:0] COIN_UNIT = 8'd5;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] balance_nxt;
    logic [1:0] item_nxt;
    logic       coin_rej_nxt;
    logic       sel_rej_nxt;
    logic [7:0] coin_val;
    logic [8:0] coin_sum;
    logic       coin_ok;
    logic [7:0] sel_price;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return 8'd5;
            2'b10:   return 8'd10;
            2'b11:   return 8'd20;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'd15;
            2'd1:    return 8'd20;
            2'd2:    return 8'd25;
            default: return 8'd30;
        endcase
    endfunction

    assign coin_val  = coin_value(coin_code);
    assign coin_sum  = {1'b0, balance} + {1'b0, coin_val};
    assign coin_ok   = coin_valid && (coin_val != 8'd0) && (coin_sum <= MAX_BAL_W);
    assign sel_price = price_of(sel);

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] wd_nxt;
    logic [7:0]      price_q;
    logic [7:0]      price_nxt;
    logic            fault_nxt;
`endif

    always_comb begin
        state_nxt    = state;
        balance_nxt  = balance;
        item_nxt     = disp_item;
        coin_rej_nxt = 1'b0;
        sel_rej_nxt  = 1'b0;
`ifdef VEND_TIMEOUT_EN
        wd_nxt       = watchdog;
        price_nxt    = price_q;
        fault_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // decisions use the registered balance; a same-cycle coin never funds them
                if (cancel && (balance != 8'd0)) begin
                    state_nxt    = CHANGE;
                    coin_rej_nxt = coin_valid;
                end else if (sel_valid && (balance >= sel_price)) begin
                    state_nxt    = VEND;
                    item_nxt     = sel;
                    balance_nxt  = balance - sel_price;
                    coin_rej_nxt = coin_valid;
`ifdef VEND_TIMEOUT_EN
                    price_nxt    = sel_price;
                    wd_nxt       = WD_LOAD;
`endif
                end else begin
                    sel_rej_nxt = sel_valid;
                    if (coin_ok) begin
                        balance_nxt = coin_sum[7:0];
                    end else begin
                        coin_rej_nxt = coin_valid;
                    end
                end
            end
            VEND: begin
                coin_rej_nxt = coin_valid;
                if (disp_ack) begin
                    state_nxt = (balance != 8'd0) ? CHANGE : IDLE;
`ifdef VEND_TIMEOUT_EN
                end else if (watchdog == '0) begin
                    fault_nxt   = 1'b1;
                    balance_nxt = balance + price_q;
                    state_nxt   = CHANGE;
                end else begin
                    wd_nxt = watchdog - WD_W'(1);
`endif
                end
            end
            CHANGE: begin
                coin_rej_nxt = coin_valid;
                if (balance == 8'd0) begin
                    state_nxt = IDLE;
                end else if (chg_ack) begin
                    balance_nxt = balance - COIN_UNIT;
                    if (balance == COIN_UNIT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            balance   <= 8'd0;
            disp_item <= 2'd0;
            disp_req  <= 1'b0;
            chg_req   <= 1'b0;
            busy      <= 1'b0;
            coin_rej  <= 1'b0;
            sel_rej   <= 1'b0;
        end else begin
            state     <= state_nxt;
            balance   <= balance_nxt;
            disp_item <= item_nxt;
            disp_req  <= (state_nxt == VEND);
            chg_req   <= (state_nxt == CHANGE);
            busy      <= (state_nxt != IDLE);
            coin_rej  <= coin_rej_nxt;
            sel_rej   <= sel_rej_nxt;
        end
    end

`ifdef VEND_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            watchdog <= '0;
            price_q  <= 8'd0;
            fault    <= 1'b0;
        end else begin
            watchdog <= wd_nxt;
            price_q  <= price_nxt;
            fault    <= fault_nxt;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule
